// File: rtl/display_scan_ctrl.sv
// Scan controller for a bank of common-anode 7-segment digits sharing one BCD decoder; frame-aligned double-buffered value.
// Optional LEADING_ZERO_BLANK_EN: drive blank code (4'hF) on leading-zero digits above digit 0.
`timescale 1ns/1ps

module display_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4*DIGITS;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV-1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS-1);
  localparam logic [CW:0]   BLANK_END = (CW+1)'(BLANK);

  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_idx;
  logic [VW-1:0]   r_disp;
  logic [VW-1:0]   r_pend;
  logic            r_pend_v;
  logic [3:0]      r_bcd;
  logic [DIGITS-1:0] r_an;
  logic            r_frame_tick;

  logic            w_slot_end;
  logic            w_wrap;
  logic [CW-1:0]   w_cnt_nxt;
  logic [IW-1:0]   w_idx_nxt;
  logic [VW-1:0]   w_disp_nxt;
  logic [VW-1:0]   w_pend_nxt;
  logic            w_pend_v_nxt;
  logic            w_in_blank;
  logic [IW+1:0]   w_nib_sel;
  logic            w_lz;
  logic [3:0]      w_bcd_nxt;
  logic [DIGITS-1:0] w_an_nxt;

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);

  always_comb begin
    w_cnt_nxt    = w_slot_end ? '0 : r_cnt + 1'b1;
    w_idx_nxt    = r_idx;
    if (w_slot_end) begin
      w_idx_nxt = w_wrap ? '0 : r_idx + 1'b1;
    end
    // Frame boundary swaps in the shadow; a same-edge load refills it and keeps it pending.
    w_disp_nxt   = (w_wrap && r_pend_v) ? r_pend : r_disp;
    w_pend_nxt   = load ? value : r_pend;
    w_pend_v_nxt = load ? 1'b1 : (w_wrap ? 1'b0 : r_pend_v);
  end

  // Outputs are decoded from next-state so the flops line up with the state they describe.
  always_comb begin
    w_in_blank = ({1'b0, w_cnt_nxt} < BLANK_END);
    w_an_nxt   = '1;
    if (!w_in_blank) begin
      w_an_nxt[w_idx_nxt] = 1'b0;
    end
    w_nib_sel = {w_idx_nxt, 2'b00};
`ifdef LEADING_ZERO_BLANK_EN
    w_lz = (w_idx_nxt != '0) && ((w_disp_nxt >> w_nib_sel) == '0);
`else
    w_lz = 1'b0;
`endif
    w_bcd_nxt = w_lz ? 4'hF : w_disp_nxt[w_nib_sel +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pend_v     <= 1'b0;
      r_bcd        <= 4'h0;
      r_an         <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_disp       <= w_disp_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_v     <= w_pend_v_nxt;
      r_bcd        <= w_bcd_nxt;
      r_an         <= w_an_nxt;
      r_frame_tick <= w_wrap;
    end
  end

  assign bcd        = r_bcd;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: time-indexed reference model plus directed checks (DIGITS=4, DIV=8, BLANK=2).
`timescale 1ns/1ps

module tb_display_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS*DIV;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int fo = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .bcd(bcd), .an(an), .frame_tick(frame_tick)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: position in the frame follows from cycles elapsed since reset.
  int          m_t;
  logic [15:0] m_disp, m_pend;
  bit          m_pv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_disp <= 16'h0; m_pend <= 16'h0; m_pv <= 1'b0;
    end else begin
      m_t <= m_t + 1;
      if ((m_t % FRAME) == FRAME-1 && m_pv) m_disp <= m_pend;
      if (load) begin
        m_pend <= value;
        m_pv   <= 1'b1;
      end else if ((m_t % FRAME) == FRAME-1) begin
        m_pv <= 1'b0;
      end
    end
  end

  function automatic logic [3:0] exp_an(input int t);
    logic [3:0] a;
    int slot;
    a = 4'hF;
    slot = (t / DIV) % DIGITS;
    if ((t % DIV) >= BLANK) a[slot] = 1'b0;
    return a;
  endfunction

  function automatic logic [3:0] exp_bcd(input int t, input logic [15:0] d);
    int slot;
    logic [15:0] up;
    slot = (t / DIV) % DIGITS;
    up = d >> (4*slot);
    if (LZ && slot > 0 && up == 16'h0) return 4'hF;
    return up[3:0];
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("model_an", an, exp_an(m_t));
      chk("model_bcd", bcd, exp_bcd(m_t, m_disp));
      chk("model_frame_tick", frame_tick, (m_t > 0 && (m_t % FRAME) == 0));
    end
  end

  task automatic tick();
    @(negedge clk);
    fo = (fo + 1) % FRAME;
  endtask

  task automatic goto(input int off);
    while (fo != off) tick();
  endtask

  task automatic next_frame();
    tick();
    goto(0);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; value = v;
    tick();
    load = 1'b0;
  endtask

  logic [3:0] rel_seq [11];
  logic [3:0] lzv;

  initial begin
    rel_seq = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};
    lzv = LZ ? 4'hF : 4'h0;

    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_an", an, 4'hF);
      chk("rst_bcd", bcd, 4'h0);
      chk("rst_ft", frame_tick, 1'b0);
    end
    mon_en = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k > 0) @(negedge clk);
      chk("release_an_seq", an, rel_seq[k]);
    end

    // Scan order
    @(negedge clk);
    load = 1'b1; value = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    begin
      int n;
      n = 0;
      while (!frame_tick && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    chk("first_frame_tick_seen", frame_tick, 1'b1);
    fo = 0;
    chk("scan_frame_start_bcd", bcd, 4'h4);
    goto(2);  chk("scan_d0_bcd", bcd, 4'h4); chk("scan_d0_an", an, 4'b1110);
    goto(10); chk("scan_d1_bcd", bcd, 4'h3); chk("scan_d1_an", an, 4'b1101);
    goto(18); chk("scan_d2_bcd", bcd, 4'h2); chk("scan_d2_an", an, 4'b1011);
    goto(26); chk("scan_d3_bcd", bcd, 4'h1); chk("scan_d3_an", an, 4'b0111);
    goto(31); chk("ft_low_before_period", frame_tick, 1'b0);
    tick();   chk("ft_period_32", frame_tick, 1'b1);

    // Tear-free update
    goto(18); do_load(16'h5678);
    chk("tear_still_old_d2", bcd, 4'h2);
    goto(26); chk("tear_still_old_d3", bcd, 4'h1);
    next_frame();
    chk("tear_new_with_ft", frame_tick, 1'b1);
    chk("tear_new_d0", bcd, 4'h8);
    goto(26); chk("tear_new_d3", bcd, 4'h5);

    // Simultaneous load and boundary
    goto(5); do_load(16'h1111);
    goto(31);
    load = 1'b1; value = 16'h2222;
    tick();
    load = 1'b0;
    chk("simul_ft", frame_tick, 1'b1);
    chk("simul_first_d0", bcd, 4'h1);
    goto(10); chk("simul_first_d1", bcd, 4'h1);
    next_frame(); chk("simul_second_d0", bcd, 4'h2);
    goto(26); chk("simul_second_d3", bcd, 4'h2);

    // Leading zeros
    goto(4); do_load(16'h0070);
    next_frame();
    goto(2);  chk("lz_d0", bcd, 4'h0);
    goto(10); chk("lz_d1", bcd, 4'h7);
    goto(18); chk("lz_d2", bcd, lzv);
    goto(26); chk("lz_d3", bcd, lzv);

    // Asynchronous reset during digit 1 SHOW, with a value still pending
    next_frame();
    goto(8); do_load(16'h9999);
    goto(12); chk("pre_rst_an", an, 4'b1101);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", an, 4'hF);
    chk("async_rst_bcd", bcd, 4'h0);
    chk("async_rst_ft", frame_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    fo = 0;
    goto(2);  chk("post_rst_d0_bcd", bcd, 4'h0); chk("post_rst_d0_an", an, 4'b1110);
    goto(10); chk("post_rst_d1_bcd", bcd, lzv);
    goto(31); tick();
    chk("post_rst_ft", frame_tick, 1'b1);
    chk("pending_discarded_d0", bcd, 4'h0);
    goto(26); chk("pending_discarded_d3", bcd, lzv);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
